// File: rtl/ram_dma.sv
// Single-command DMA engine for a 64Kx8 asynchronous-read RAM: FILL (constant or
// incrementing pattern) and COPY (ascending byte-by-byte) with abort support.
module ram_dma #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W-1:0] i_len,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_enable_x,
    output logic              o_ram_write_x,
    output logic [DATA_W-1:0] o_ram_data,
    input  logic [DATA_W-1:0] i_ram_data
);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCopyRd,
        StCopyWr,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    // Remaining bytes; a count of 0 wraps through all values, giving 2^ADDR_W bytes.
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              inc_q, inc_d;
    logic              aborted_q, aborted_d;

    logic              last_byte;
    assign last_byte = (cnt_q == ADDR_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            val_q     <= '0;
            hold_q    <= '0;
            inc_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            val_q     <= val_d;
            hold_q    <= hold_d;
            inc_q     <= inc_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        val_d     = val_q;
        hold_d    = hold_q;
        inc_d     = inc_q;
        aborted_d = aborted_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    src_d     = i_src;
                    dst_d     = i_dst;
                    cnt_d     = i_len;
                    val_d     = i_pattern;
                    inc_d     = (i_op == 2'd1);
                    aborted_d = 1'b0;
                    unique case (i_op)
                        2'd0, 2'd1: state_d = StFill;
                        2'd2:       state_d = StCopyRd;
                        default:    state_d = StFin;
                    endcase
                end
            end
            StFill: begin
                if (i_abort) begin
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else begin
                    dst_d = dst_q + ADDR_W'(1);
                    cnt_d = cnt_q - ADDR_W'(1);
                    if (inc_q) begin
                        val_d = val_q + DATA_W'(1);
                    end
                    if (last_byte) begin
                        state_d = StFin;
                    end
                end
            end
            StCopyRd: begin
                if (i_abort) begin
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else begin
                    hold_d  = i_ram_data;
                    state_d = StCopyWr;
                end
            end
            StCopyWr: begin
                if (i_abort) begin
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else begin
                    src_d   = src_q + ADDR_W'(1);
                    dst_d   = dst_q + ADDR_W'(1);
                    cnt_d   = cnt_q - ADDR_W'(1);
                    state_d = last_byte ? StFin : StCopyRd;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // RAM pins come straight from registered state; only the write strobe sees i_abort.
    always_comb begin
        o_ram_addr     = '0;
        o_ram_enable_x = 1'b1;
        o_ram_write_x  = 1'b1;
        o_ram_data     = '0;
        unique case (state_q)
            StFill: begin
                o_ram_addr     = dst_q;
                o_ram_enable_x = 1'b0;
                o_ram_write_x  = i_abort;
                o_ram_data     = val_q;
            end
            StCopyRd: begin
                o_ram_addr     = src_q;
                o_ram_enable_x = 1'b0;
            end
            StCopyWr: begin
                o_ram_addr     = dst_q;
                o_ram_enable_x = 1'b0;
                o_ram_write_x  = i_abort;
                o_ram_data     = hold_q;
            end
            default: begin
            end
        endcase
    end

    assign o_busy    = (state_q == StFill) || (state_q == StCopyRd) || (state_q == StCopyWr);
    assign o_done    = (state_q == StFin);
    assign o_aborted = aborted_q;

endmodule

// File: tb/tb_ram_dma.sv
// Randomized bench for ram_dma: a byte-array RAM behind the DUT, checked against a
// command-level reference model of memory contents, write order and timing.
module tb_ram_dma;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [15:0] i_src;
    logic [15:0] i_dst;
    logic [15:0] i_len;
    logic [7:0]  i_pattern;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic        o_aborted;
    logic [15:0] o_ram_addr;
    logic        o_ram_enable_x;
    logic        o_ram_write_x;
    logic [7:0]  o_ram_data;
    logic [7:0]  i_ram_data;

    int total = 0;
    int bad   = 0;

    bit [7:0]    ram     [65536];
    bit [7:0]    ref_mem [65536];
    logic [23:0] act_wr[$];
    logic [23:0] exp_wr[$];

    ram_dma #(
        .ADDR_W(16),
        .DATA_W(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_src         (i_src),
        .i_dst         (i_dst),
        .i_len         (i_len),
        .i_pattern     (i_pattern),
        .i_abort       (i_abort),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_aborted     (o_aborted),
        .o_ram_addr    (o_ram_addr),
        .o_ram_enable_x(o_ram_enable_x),
        .o_ram_write_x (o_ram_write_x),
        .o_ram_data    (o_ram_data),
        .i_ram_data    (i_ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_ram_data = ram[o_ram_addr];

    always @(posedge clk) begin
        if (!rst && !o_ram_enable_x && !o_ram_write_x) begin
            ram[o_ram_addr] <= o_ram_data;
            act_wr.push_back({o_ram_addr, o_ram_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write strobe must never go low while the chip is deselected.
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe", 32'(o_ram_enable_x && !o_ram_write_x), 32'd0);
        end
    end

    // Command-level model: which bytes land where, and when done/busy/aborted appear.
    task automatic model(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input logic [7:0] pat, input int abort_at,
                         output int lat, output int busy_n, output bit ab);
        int n;
        int nwr;
        logic [15:0] a;
        logic [7:0]  d;
        n = (len == 16'd0) ? 65536 : int'(len);
        exp_wr.delete();
        ab = 1'b0;
        if (op == 2'd3) begin
            lat = 1;
            busy_n = 0;
            nwr = 0;
        end else begin
            int active;
            active = (op == 2'd2) ? 2 * n : n;
            if (abort_at >= 1 && abort_at <= active) begin
                ab = 1'b1;
                lat = abort_at + 1;
                busy_n = abort_at;
                nwr = (op == 2'd2) ? (abort_at - 1) / 2 : abort_at - 1;
            end else begin
                lat = active + 1;
                busy_n = active;
                nwr = n;
            end
        end
        for (int i = 0; i < nwr; i++) begin
            if (op == 2'd2) begin
                d = ref_mem[16'(src + 16'(i))];
            end else if (op == 2'd1) begin
                d = 8'(pat + 8'(i));
            end else begin
                d = pat;
            end
            a = 16'(dst + 16'(i));
            ref_mem[a] = d;
            exp_wr.push_back({a, d});
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input logic [7:0] pat, input int abort_at,
                           input bit ab_with_start, input bit inject);
        int lat;
        int busy_exp;
        int busy_n;
        int nbad;
        bit ab_exp;
        bit seen;
        model(op, src, dst, len, pat, abort_at, lat, busy_exp, ab_exp);
        act_wr.delete();
        @(negedge clk);
        i_op      = op;
        i_src     = src;
        i_dst     = dst;
        i_len     = len;
        i_pattern = pat;
        i_start   = 1'b1;
        i_abort   = ab_with_start;
        @(posedge clk);
        #1;
        // Scramble command inputs to prove they were latched.
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_op      = 2'($urandom);
        i_src     = 16'($urandom);
        i_dst     = 16'($urandom);
        i_len     = 16'($urandom);
        i_pattern = 8'($urandom);
        seen   = 1'b0;
        busy_n = 0;
        for (int k = 1; k <= lat + 4 && !seen; k++) begin
            i_abort = (k == abort_at);
            i_start = inject && (k == 2) && (lat > 2);
            @(negedge clk);
            if (k == 1) chk("aborted_clr", 32'(o_aborted), 32'd0);
            if (o_busy) busy_n++;
            if (o_done) begin
                seen = 1'b1;
                chk("latency", k, lat);
                chk("aborted", 32'(o_aborted), 32'(ab_exp));
            end
            @(posedge clk);
            #1;
        end
        i_abort = 1'b0;
        i_start = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("busy_cycles", busy_n, busy_exp);
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 32'd0);
        chk("busy_idle", 32'(o_busy), 32'd0);
        chk("aborted_hold", 32'(o_aborted), 32'(ab_exp));
        chk("n_writes", act_wr.size(), exp_wr.size());
        nbad = 0;
        for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
            if (act_wr[i] !== exp_wr[i]) nbad++;
        end
        chk("write_seq", nbad, 0);
        nbad = 0;
        for (int i = 0; i < 65536; i++) begin
            if (ram[i] != ref_mem[i]) nbad++;
        end
        chk("mem_image", nbad, 0);
    endtask

    initial begin
        rst       = 1'b1;
        i_start   = 1'b0;
        i_op      = 2'd0;
        i_src     = 16'd0;
        i_dst     = 16'd0;
        i_len     = 16'd0;
        i_pattern = 8'd0;
        i_abort   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_enable_x", 32'(o_ram_enable_x), 32'd1);
            chk("rst_write_x", 32'(o_ram_write_x), 32'd1);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
            chk("rst_aborted", 32'(o_aborted), 32'd0);
            chk("rst_addr", 32'(o_ram_addr), 32'd0);
            chk("rst_data", 32'(o_ram_data), 32'd0);
        end

        // FILL_CONST across the top of the address space.
        run_cmd(2'd0, 16'h0000, 16'hFFFE, 16'd4, 8'hA5, 0, 1'b0, 1'b0);
        chk("wrap_ffff", 32'(ram[16'hFFFF]), 32'hA5);
        chk("wrap_0001", 32'(ram[16'h0001]), 32'hA5);
        chk("wrap_0002", 32'(ram[16'h0002]), 32'h00);

        // COPY of 16 bytes from a FILL_INC-prepared source.
        run_cmd(2'd1, 16'h0000, 16'h1000, 16'd16, 8'h10, 0, 1'b0, 1'b0);
        run_cmd(2'd2, 16'h1000, 16'h2000, 16'd16, 8'h00, 0, 1'b0, 1'b1);
        chk("copy_200f", 32'(ram[16'h200F]), 32'h1F);

        // Overlapping ascending COPY replicates the first source byte.
        run_cmd(2'd0, 16'h0000, 16'h0100, 16'd1, 8'h77, 0, 1'b0, 1'b0);
        run_cmd(2'd2, 16'h0100, 16'h0101, 16'd3, 8'h00, 0, 1'b0, 1'b0);
        chk("overlap_0103", 32'(ram[16'h0103]), 32'h77);

        // Abort on the 3rd FILL cycle, then a reserved op clears the aborted flag.
        run_cmd(2'd0, 16'h0000, 16'h0040, 16'd10, 8'hFF, 3, 1'b0, 1'b0);
        chk("abort_0041", 32'(ram[16'h0041]), 32'hFF);
        chk("abort_0042", 32'(ram[16'h0042]), 32'h00);
        run_cmd(2'd3, 16'h0000, 16'h0000, 16'd5, 8'h00, 1, 1'b1, 1'b0);

        for (int r = 0; r < 14; r++) begin
            logic [1:0]  op;
            logic [15:0] len;
            int          ab_at;
            int          act;
            op    = 2'($urandom_range(0, 3));
            len   = 16'($urandom_range(1, 40));
            act   = (op == 2'd2) ? 2 * int'(len) : int'(len);
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, act)) : 0;
            if (op == 2'd3) ab_at = 1;
            run_cmd(op, 16'($urandom), 16'($urandom), len, 8'($urandom), ab_at,
                    1'($urandom), 1'($urandom));
        end

        // Full address space FILL_INC with length 0.
        run_cmd(2'd1, 16'h0000, 16'h0000, 16'd0, 8'h00, 0, 1'b0, 1'b0);
        chk("full_00ff", 32'(ram[16'h00FF]), 32'hFF);
        chk("full_1234", 32'(ram[16'h1234]), 32'h34);
        chk("full_ffff", 32'(ram[16'hFFFF]), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
